m_axi_wr_burst: RTL and testbench
=================================

Name: m_axi_wr_burst

Overview:
Parametrised AXI4 write master and the successor to the single-burst writer. It accepts one command (start address plus total beat count) and splits it into INCR bursts. Bursts are capped by MAX_BURST and never cross a 4 KB boundary. Up to MAX_OUTSTANDING bursts may await a B response, and write errors are aggregated into one done/error report per command. The block sits between a DMA/frame-buffer engine and the AXI interconnect/DDR controller.

Parameters:
ID_W, 1, AXI ID width; awid is driven constant 0
ADDR_W, 32, AXI address width
DATA_W, 64, data width; power of 2, 32..512
LEN_W, 16, width of the command beat count
MAX_BURST, 16, maximum beats per burst; 1..256
MAX_OUTSTANDING, 4, maximum AW-accepted bursts without a B response; 1..16
TIMEOUT_CYC, 4096, watchdog limit (optional feature only)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command request
cmd_ready  out  1  high in IDLE only
cmd_addr  in  ADDR_W  start byte address; low log2(DATA_W/8) bits are ignored (forced to 0)
cmd_beats  in  LEN_W  total beats to write
wr_data  in  DATA_W  user write data
wr_valid  in  1  user data valid
wr_ready  out  1  user beat consumed (wr_valid && wr_ready)
wr_done  out  1  one-cycle pulse when the command has fully completed
wr_err  out  1  valid with wr_done; 1 if any bresp[1] was set during the command
wr_timeout  out  1  sticky watchdog flag
busy  out  1  high from command accept until wr_done
axi_awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awqos/awvalid  out  std  AW channel
axi_awready  in  1
axi_wdata/wstrb/wlast/wvalid  out  std  W channel
axi_wready  in  1
axi_bid/bresp/bvalid  in  std  B channel
axi_bready  out  1

Behaviour:
- Reset values: all valid outputs, wr_done, wr_err, wr_timeout, busy and the internal counters are 0; cmd_ready=1; awaddr=0.
- Constant outputs: awsize=log2(DATA_W/8); awburst=INCR; awcache=4'b0011; awlock, awprot, awqos=0; wstrb=all ones.
- FSM states: IDLE, CALC, AW, DATA, DRAIN.
- IDLE: on cmd_valid, latch the address and remaining=cmd_beats, then go to CALC. If cmd_beats==0, skip AXI entirely and pulse wr_done (wr_err=0) on the next cycle.
- CALC (1 cycle): blen = min(remaining, MAX_BURST, (4096 - addr[11:0])/(DATA_W/8)). Go to AW if outstanding<MAX_OUTSTANDING; otherwise stay in CALC.
- AW: awvalid=1 with awaddr and awlen=blen-1 registered and held stable until awready. On the handshake, outstanding+1 and go to DATA.
- DATA: axi_wdata=wr_data, axi_wvalid=wr_valid, wr_ready=axi_wready (pass-through, zero latency).
  - beat counter counts W handshakes; wlast is high on beat blen.
  - On the wlast handshake: addr += blen*DATA_W/8 and remaining -= blen. If remaining>0 go to CALC, else go to DRAIN.
- DRAIN: wait until outstanding==0, then pulse wr_done with wr_err, and return to IDLE.
- bready=1 whenever outstanding>0. The outstanding count decrements on each B handshake; a simultaneous AW and B handshake leaves it unchanged.
- wr_err is an accumulator cleared on command accept and set by any B response with bresp[1]=1 (SLVERR or DECERR).
- A B response arriving while outstanding==0 is ignored and does not underflow the counter.
- rst mid-command: all state returns to the reset values in the next cycle. No wr_done is issued. AXI rules are not protected across reset.

Optional Feature:
Macro AXI_WR_TIMEOUT_EN.
- Defined: a cycle counter runs while busy and clears on any AW, W or B handshake. When it reaches TIMEOUT_CYC, wr_timeout sets. wr_timeout clears on the next command accept. Bus signalling is not changed.
- Undefined: wr_timeout is tied to 0 and no counter is synthesised.

Decomposition:
- Package m_axi_wr_pkg: FSM state enum; AXI constants (BURST_INCR, RESP_OKAY/EXOKAY/SLVERR/DECERR, CACHE_DEFAULT); 4 KB boundary constant; clog2 function.
- Sub-module m_axi_burst_calc: combinational computation of blen and the 4 KB boundary limit from addr, remaining and MAX_BURST; instantiated once.

Test Plan:
- DATA_W=64, MAX_BURST=16, cmd 0x1000/40 beats -> AW at 0x1000, 0x1080, 0x1100 with awlen 15, 15, 7; wlast on beats 16, 32, 40; one wr_done with wr_err=0.
- cmd 0x0FE0/10 beats -> two bursts: 0x0FE0 awlen 3, then 0x1000 awlen 5; no burst crosses 4 KB.
- MAX_OUTSTANDING=2, bvalid held 0, cmd 64 beats -> exactly 2 AW handshakes and the 3rd awvalid stays low. Releasing one B -> the 3rd AW issues within 2 cycles.
- Three bursts with bresp OKAY, SLVERR, OKAY -> wr_done with wr_err=1. Next command with all OKAY -> wr_err=0.
- Random awready/wready/wr_valid stalls over 200 beats -> data order preserved, awaddr/awlen stable while awvalid=1, wlast count equals AW count.
- cmd_beats=0 -> wr_done next cycle, no awvalid. rst=1 during DATA -> all valids 0 and cmd_ready=1 the following cycle.

Source files
------------

// File: rtl/m_axi_wr_pkg.sv
// Shared types and constants for the AXI4 multi-burst write master.
package m_axi_wr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_AW,
        ST_DATA,
        ST_DRAIN
    } state_e;

    localparam logic [1:0] BURST_INCR    = 2'b01;
    localparam logic [1:0] RESP_OKAY     = 2'b00;
    localparam logic [1:0] RESP_EXOKAY   = 2'b01;
    localparam logic [1:0] RESP_SLVERR   = 2'b10;
    localparam logic [1:0] RESP_DECERR   = 2'b11;
    localparam logic [3:0] CACHE_DEFAULT = 4'b0011;
    localparam int         BOUNDARY_4K   = 4096;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/m_axi_burst_calc.sv
// Burst length for the next AW: limited by remaining beats, MAX_BURST and the
// distance to the next 4 KB page.
module m_axi_burst_calc
    import m_axi_wr_pkg::*;
#(
    parameter int LEN_W     = 16,
    parameter int MAX_BURST = 16,
    parameter int DATA_W    = 64,
    parameter int BLEN_W    = 5
) (
    input  logic [11:0]       addr_lo,
    input  logic [LEN_W-1:0]  remaining,
    output logic [BLEN_W-1:0] blen,
    output logic [12:0]       bound_beats
);

    localparam int BYTE_SHIFT = clog2(DATA_W / 8);

    logic [12:0] bytes_left;
    logic [31:0] lim;

    always_comb begin
        // addr_lo is beat aligned, so bytes_left is an exact multiple of a beat
        bytes_left  = 13'(BOUNDARY_4K) - {1'b0, addr_lo};
        bound_beats = bytes_left >> BYTE_SHIFT;
        lim         = 32'(MAX_BURST);
        if (32'(bound_beats) < lim) lim = 32'(bound_beats);
        if (32'(remaining) < lim)   lim = 32'(remaining);
        blen = BLEN_W'(lim);
    end

endmodule

// File: rtl/m_axi_wr_burst.sv
// AXI4 write master: splits one command into 4 KB-safe INCR bursts with up to
// MAX_OUTSTANDING pending B responses. Optional watchdog: AXI_WR_TIMEOUT_EN.
module m_axi_wr_burst
    import m_axi_wr_pkg::*;
#(
    parameter int ID_W            = 1,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 64,
    parameter int LEN_W           = 16,
    parameter int MAX_BURST       = 16,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYC     = 4096
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [LEN_W-1:0]    cmd_beats,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                wr_valid,
    output logic                wr_ready,
    output logic                wr_done,
    output logic                wr_err,
    output logic                wr_timeout,
    output logic                busy,
    output logic [ID_W-1:0]     axi_awid,
    output logic [ADDR_W-1:0]   axi_awaddr,
    output logic [7:0]          axi_awlen,
    output logic [2:0]          axi_awsize,
    output logic [1:0]          axi_awburst,
    output logic                axi_awlock,
    output logic [3:0]          axi_awcache,
    output logic [2:0]          axi_awprot,
    output logic [3:0]          axi_awqos,
    output logic                axi_awvalid,
    input  logic                axi_awready,
    output logic [DATA_W-1:0]   axi_wdata,
    output logic [DATA_W/8-1:0] axi_wstrb,
    output logic                axi_wlast,
    output logic                axi_wvalid,
    input  logic                axi_wready,
    input  logic [ID_W-1:0]     axi_bid,
    input  logic [1:0]          axi_bresp,
    input  logic                axi_bvalid,
    output logic                axi_bready
);

    localparam int BYTE_SHIFT = clog2(DATA_W / 8);
    localparam int BLEN_W     = clog2(MAX_BURST + 1);
    localparam int OUT_W      = clog2(MAX_OUTSTANDING + 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    rem_q, rem_d;
    logic [BLEN_W-1:0]   blen_q, blen_d;
    logic [BLEN_W-1:0]   beat_q, beat_d;
    logic [OUT_W-1:0]    out_q, out_d;
    logic                err_q, err_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;

    logic [BLEN_W-1:0]   calc_blen;
    logic [12:0]         bound_beats;
    logic                aw_fire, w_fire, b_fire;

    m_axi_burst_calc #(
        .LEN_W     (LEN_W),
        .MAX_BURST (MAX_BURST),
        .DATA_W    (DATA_W),
        .BLEN_W    (BLEN_W)
    ) u_calc (
        .addr_lo     (addr_q[11:0]),
        .remaining   (rem_q),
        .blen        (calc_blen),
        .bound_beats (bound_beats)
    );

    assign cmd_ready   = (state_q == ST_IDLE);
    assign busy        = busy_q;
    assign wr_done     = done_q;
    assign wr_err      = err_q;

    assign axi_awid    = '0;
    assign axi_awaddr  = addr_q;
    assign axi_awlen   = 8'(blen_q - BLEN_W'(1));
    assign axi_awsize  = 3'(BYTE_SHIFT);
    assign axi_awburst = BURST_INCR;
    assign axi_awlock  = 1'b0;
    assign axi_awcache = CACHE_DEFAULT;
    assign axi_awprot  = 3'b000;
    assign axi_awqos   = 4'b0000;
    assign axi_awvalid = (state_q == ST_AW);

    // W channel is a zero-latency pass-through of the user stream while in DATA
    assign axi_wdata   = wr_data;
    assign axi_wstrb   = '1;
    assign axi_wvalid  = (state_q == ST_DATA) && wr_valid;
    assign wr_ready    = (state_q == ST_DATA) && axi_wready;
    assign axi_wlast   = (state_q == ST_DATA) && (beat_q == blen_q - BLEN_W'(1));
    assign axi_bready  = (out_q != '0);

    assign aw_fire = axi_awvalid && axi_awready;
    assign w_fire  = axi_wvalid && axi_wready;
    assign b_fire  = axi_bvalid && axi_bready;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        blen_d  = blen_q;
        beat_d  = beat_q;
        out_d   = out_q;
        err_d   = err_q;
        done_d  = 1'b0;
        busy_d  = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    addr_d = {cmd_addr[ADDR_W-1:BYTE_SHIFT], {BYTE_SHIFT{1'b0}}};
                    rem_d  = cmd_beats;
                    err_d  = 1'b0;
                    if (cmd_beats == '0) begin
                        done_d = 1'b1;
                    end else begin
                        busy_d  = 1'b1;
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                blen_d = calc_blen;
                if (out_q < OUT_W'(MAX_OUTSTANDING)) state_d = ST_AW;
            end
            ST_AW: begin
                if (axi_awready) begin
                    beat_d  = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_fire) begin
                    beat_d = beat_q + BLEN_W'(1);
                    if (axi_wlast) begin
                        addr_d  = addr_q + (ADDR_W'(blen_q) << BYTE_SHIFT);
                        rem_d   = rem_q - LEN_W'(blen_q);
                        state_d = (rem_q == LEN_W'(blen_q)) ? ST_DRAIN : ST_CALC;
                    end
                end
            end
            ST_DRAIN: begin
                if (out_q == '0) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // bready is gated by out_q != 0, so a B handshake can never underflow
        case ({aw_fire, b_fire})
            2'b10:   out_d = out_q + OUT_W'(1);
            2'b01:   out_d = out_q - OUT_W'(1);
            default: out_d = out_q;
        endcase

        if (b_fire && axi_bresp[1]) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            blen_q  <= '0;
            beat_q  <= '0;
            out_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            blen_q  <= blen_d;
            beat_q  <= beat_d;
            out_q   <= out_d;
            err_q   <= err_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

`ifdef AXI_WR_TIMEOUT_EN
    localparam int TMO_W = clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             tmo_q, tmo_d;

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        tmo_d     = tmo_q;
        if (!busy_q || aw_fire || w_fire || b_fire) begin
            tmo_cnt_d = '0;
        end else if (tmo_cnt_q != TMO_W'(TIMEOUT_CYC)) begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
        if (tmo_cnt_q == TMO_W'(TIMEOUT_CYC)) tmo_d = 1'b1;
        if (cmd_valid && cmd_ready)            tmo_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            tmo_q     <= tmo_d;
        end
    end

    assign wr_timeout = tmo_q;
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_CYC == 0);
    assign wr_timeout = 1'b0;
`endif

    logic unused_ok;
    assign unused_ok = ^{axi_bid, axi_bresp[0], cmd_addr[BYTE_SHIFT-1:0], bound_beats};

endmodule

// File: tb/tb_m_axi_wr_burst.sv
// Scoreboard bench for m_axi_wr_burst (DATA_W=64, MAX_BURST=16, MAX_OUTSTANDING=2).
`timescale 1ns/1ps
module tb_m_axi_wr_burst;
    import m_axi_wr_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr = '0;
    logic [15:0] cmd_beats = '0;
    logic [63:0] wr_data = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready, wr_done, wr_err, wr_timeout, busy;
    logic [0:0]  axi_awid;
    logic [31:0] axi_awaddr;
    logic [7:0]  axi_awlen;
    logic [2:0]  axi_awsize;
    logic [1:0]  axi_awburst;
    logic        axi_awlock;
    logic [3:0]  axi_awcache;
    logic [2:0]  axi_awprot;
    logic [3:0]  axi_awqos;
    logic        axi_awvalid;
    logic        axi_awready = 1'b1;
    logic [63:0] axi_wdata;
    logic [7:0]  axi_wstrb;
    logic        axi_wlast, axi_wvalid;
    logic        axi_wready = 1'b1;
    logic [0:0]  axi_bid = '0;
    logic [1:0]  axi_bresp = '0;
    logic        axi_bvalid = 1'b0;
    logic        axi_bready;

    always #5 clk = ~clk;

    m_axi_wr_burst #(
        .ID_W(1), .ADDR_W(32), .DATA_W(64), .LEN_W(16),
        .MAX_BURST(16), .MAX_OUTSTANDING(2), .TIMEOUT_CYC(4096)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_done(wr_done), .wr_err(wr_err), .wr_timeout(wr_timeout), .busy(busy),
        .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
        .axi_awburst(axi_awburst), .axi_awlock(axi_awlock), .axi_awcache(axi_awcache),
        .axi_awprot(axi_awprot), .axi_awqos(axi_awqos), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast), .axi_wvalid(axi_wvalid),
        .axi_wready(axi_wready),
        .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready)
    );

    typedef struct { logic [31:0] addr; logic [7:0] len; } aw_t;
    typedef struct { logic [63:0] data; logic last; } w_t;

    aw_t  exp_aw[$];
    w_t   exp_w[$];
    logic exp_done[$];
    aw_t  mon_aw;
    w_t   mon_w;
    logic mon_d;

    int n_cmp = 0;
    int n_err = 0;
    int exp_idx = 0;

    function automatic logic [63:0] pat(input int k);
        return {32'hC0DE_0000 + 32'(k), ~32'(k)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic exp_burst(input logic [31:0] addr, input int len);
        exp_aw.push_back('{addr, 8'(len)});
        for (int i = 0; i <= len; i++) begin
            exp_w.push_back('{pat(exp_idx), (i == len)});
            exp_idx++;
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic        aw_fire_s = 0, w_fire_s = 0, wr_fire_s = 0, b_fire_s = 0;
    int          aw_cnt = 0, wlast_cnt = 0, b_cnt = 0;
    logic        stall_pend = 0;
    logic [31:0] stall_addr = '0;
    logic [7:0]  stall_len = '0;

    always @(negedge clk) begin
        aw_fire_s = axi_awvalid && axi_awready;
        w_fire_s  = axi_wvalid && axi_wready;
        wr_fire_s = wr_valid && wr_ready;
        b_fire_s  = axi_bvalid && axi_bready;
        if (!rst) begin
            if (stall_pend && axi_awvalid) begin
                check("awaddr_stable", axi_awaddr, stall_addr);
                check("awlen_stable", axi_awlen, stall_len);
            end
            stall_pend = axi_awvalid && !axi_awready;
            stall_addr = axi_awaddr;
            stall_len  = axi_awlen;
            if (aw_fire_s) begin
                aw_cnt++;
                $display("AW  addr=0x%08h len=%0d", axi_awaddr, axi_awlen);
                if (exp_aw.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_aw: got addr 0x%0h, none expected", axi_awaddr);
                end else begin
                    mon_aw = exp_aw.pop_front();
                    check("awaddr", axi_awaddr, mon_aw.addr);
                    check("awlen", axi_awlen, mon_aw.len);
                end
            end
            if (w_fire_s) begin
                $display("W   data=0x%016h last=%0b", axi_wdata, axi_wlast);
                if (axi_wlast) wlast_cnt++;
                if (exp_w.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_w: got data 0x%0h, none expected", axi_wdata);
                end else begin
                    mon_w = exp_w.pop_front();
                    check("wdata", axi_wdata, mon_w.data);
                    check("wlast", axi_wlast, mon_w.last);
                end
            end
            if (b_fire_s) begin
                b_cnt++;
                $display("B   resp=%0d", axi_bresp);
            end
            if (wr_done) begin
                $display("DONE err=%0b", wr_err);
                if (exp_done.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_done: got wr_done=1, required 0");
                end else begin
                    mon_d = exp_done.pop_front();
                    check("wr_err", wr_err, mon_d);
                end
            end
        end else begin
            stall_pend = 0;
        end
    end

    // ---------------- stimulus drivers ----------------
    int         data_idx = 0;
    logic       rnd = 0;
    int         b_limit = 1000;
    int         b_issued = 0;
    logic [1:0] resp_plan [0:63];

    always @(posedge clk) begin
        #1;
        if (rst) begin
            axi_bvalid = 1'b0;
            b_issued   = wlast_cnt;
        end else begin
            if (wr_fire_s) data_idx++;
            wr_data = pat(data_idx);
            if (!wr_valid || wr_fire_s) wr_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            axi_awready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            axi_wready  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (b_fire_s) axi_bvalid = 1'b0;
            if (!axi_bvalid && b_issued < wlast_cnt && b_issued < b_limit &&
                (!rnd || $urandom_range(0, 1) == 1)) begin
                axi_bresp  = (b_issued < 64) ? resp_plan[b_issued] : RESP_OKAY;
                axi_bvalid = 1'b1;
                b_issued++;
            end
        end
    end

    task automatic send_cmd(input logic [31:0] a, input logic [15:0] n);
        int t;
        t = 0;
        @(negedge clk);
        while (!cmd_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (!cmd_ready) begin
            n_err++;
            $display("FAIL cmd_accept_timeout: cmd_ready=0 after %0d cycles, required 1", t);
        end else begin
            cmd_addr  = a;
            cmd_beats = n;
            cmd_valid = 1'b1;
            @(posedge clk);
            #1 cmd_valid = 1'b0;
            $display("CMD addr=0x%08h beats=%0d", a, n);
        end
    endtask

    task automatic wait_all(input string name, input int budget);
        int t;
        t = 0;
        while ((exp_aw.size() + exp_w.size() + exp_done.size()) != 0 && t < budget) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (t >= budget) begin
            n_err++;
            $display("FAIL %s_timeout: aw=%0d w=%0d done=%0d still pending, required 0",
                     name, exp_aw.size(), exp_w.size(), exp_done.size());
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int a0, w0, bb, t, lat;
        for (int i = 0; i < 64; i++) resp_plan[i] = RESP_OKAY;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_awvalid", axi_awvalid, 0);
        check("rst_wvalid", axi_wvalid, 0);
        check("rst_bready", axi_bready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", wr_done, 0);
        check("rst_timeout", wr_timeout, 0);
        check("rst_awaddr", axi_awaddr, 0);
        #1 rst = 1'b0;
        @(negedge clk);
        check("awsize", axi_awsize, 3);
        check("awburst", axi_awburst, 1);
        check("awcache", axi_awcache, 4'b0011);
        check("awlock_prot_qos", {axi_awlock, axi_awprot, axi_awqos}, 0);
        check("wstrb", axi_wstrb, 8'hFF);

        // 40 beats from a page start: 16 + 16 + 8
        a0 = aw_cnt; w0 = wlast_cnt;
        exp_burst(32'h1000, 15); exp_burst(32'h1080, 15); exp_burst(32'h1100, 7);
        exp_done.push_back(1'b0);
        send_cmd(32'h1000, 16'd40);
        @(negedge clk);
        check("busy_after_accept", busy, 1);
        check("cmd_ready_busy", cmd_ready, 0);
        wait_all("cmd40", 2000);
        check("cmd40_aw_count", aw_cnt - a0, 3);
        check("cmd40_wlast_count", wlast_cnt - w0, 3);

        // 4 KB split: 4 beats to the page end, then 6
        exp_burst(32'h0FE0, 3); exp_burst(32'h1000, 5);
        exp_done.push_back(1'b0);
        send_cmd(32'h0FE0, 16'd10);
        wait_all("cross4k", 2000);

        // outstanding limit with B withheld
        b_limit = wlast_cnt;
        a0 = aw_cnt; w0 = wlast_cnt;
        for (int i = 0; i < 4; i++) exp_burst(32'h4000 + 32'(i * 128), 15);
        exp_done.push_back(1'b0);
        send_cmd(32'h4000, 16'd64);
        t = 0;
        while (wlast_cnt < w0 + 2 && t < 500) begin @(negedge clk); t++; end
        repeat (20) @(negedge clk);
        check("outst_aw_count", aw_cnt - a0, 2);
        check("outst_awvalid_low", axi_awvalid, 0);
        b_limit = b_limit + 1;
        t = 0;
        while (!(axi_bvalid && axi_bready) && t < 20) begin @(negedge clk); t++; end
        lat = 0;
        do begin @(negedge clk); lat++; end while (!axi_awvalid && lat < 10);
        check("third_aw_latency_le2", (lat <= 2), 1);
        b_limit = 1000;
        wait_all("outst", 3000);

        // error aggregation: OKAY, SLVERR, OKAY, then a clean command
        bb = wlast_cnt;
        resp_plan[bb + 1] = RESP_SLVERR;
        for (int i = 0; i < 3; i++) exp_burst(32'h5000 + 32'(i * 128), 15);
        exp_done.push_back(1'b1);
        send_cmd(32'h5000, 16'd48);
        wait_all("err", 2000);
        exp_burst(32'h6000, 15);
        exp_done.push_back(1'b0);
        send_cmd(32'h6000, 16'd16);
        wait_all("err_clear", 2000);

        // 200 beats under random stalls: 12 x 16 + 8
        rnd = 1'b1;
        a0 = aw_cnt; w0 = wlast_cnt;
        for (int i = 0; i < 12; i++) exp_burst(32'h2000 + 32'(i * 128), 15);
        exp_burst(32'h2600, 7);
        exp_done.push_back(1'b0);
        send_cmd(32'h2000, 16'd200);
        wait_all("random", 8000);
        rnd = 1'b0;
        check("random_aw_count", aw_cnt - a0, 13);
        check("random_wlast_eq_aw", wlast_cnt - w0, aw_cnt - a0);

        // zero-beat command
        a0 = aw_cnt;
        exp_done.push_back(1'b0);
        send_cmd(32'h8000, 16'd0);
        @(negedge clk);
        check("zero_done_next_cycle", wr_done, 1);
        check("zero_awvalid", axi_awvalid, 0);
        repeat (5) @(negedge clk);
        check("zero_aw_count", aw_cnt - a0, 0);
        wait_all("zero", 100);

        // reset in the middle of DATA
        exp_burst(32'h7000, 15); exp_burst(32'h7080, 15);
        send_cmd(32'h7000, 16'd32);
        t = 0;
        while (exp_w.size() > 24 && t < 500) begin @(negedge clk); t++; end
        check("reset_test_reached_data", axi_wvalid, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        exp_aw.delete();
        exp_w.delete();
        @(negedge clk);
        @(negedge clk);
        check("midrst_awvalid", axi_awvalid, 0);
        check("midrst_wvalid", axi_wvalid, 0);
        check("midrst_bready", axi_bready, 0);
        check("midrst_cmd_ready", cmd_ready, 1);
        check("midrst_busy", busy, 0);
        check("midrst_done", wr_done, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(negedge clk);
        check("post_rst_idle", cmd_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
